data_mem_loader: RTL

DATA_MEM_LOADER -- requirements
Module: data_mem_loader

---
 rtl/data_mem_loader_pkg.sv | 22 ++
 rtl/data_mem_loader_byte_assembler.sv | 38 +++
 rtl/data_mem_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/data_mem_loader_pkg.sv
// Shared definitions for the data memory preload path: state encoding,
// word geometry and the word-count clamp.
package data_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = 256;
    localparam int ADDR_W         = 8;
    localparam int COUNT_W        = 9;

    // Loader FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t WRITE   = 2'd2;
    localparam state_t FINISH  = 2'd3;

    // Requests larger than the memory depth are trimmed to a full-memory load
    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] n);
        return (n > COUNT_W'(MAX_WORDS)) ? COUNT_W'(MAX_WORDS) : n;
    endfunction

endpackage

// File: rtl/data_mem_loader_byte_assembler.sv
// Collects four serial bytes into one 32-bit word. Each byte is inserted
// into its final lane, so the word register is complete once the fourth
// byte has been taken.
module byte_assembler
    import data_mem_loader_pkg::*;
#(
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        data_reset,
    input  logic        clear,
    input  logic        load_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_idx,
    output logic        last_byte
);

    logic [1:0] lane;

    assign lane      = (LITTLE_ENDIAN != 0) ? byte_idx : (2'd3 - byte_idx);
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

    // Insert the accepted byte into its lane; a clear drops any partial word
    always_ff @(posedge clk or posedge data_reset) begin
        if (data_reset) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (load_en) begin
            word[{lane, 3'b000} +: 8] <= byte_in;
            byte_idx                  <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/data_mem_loader.sv
// Serial-to-word loader that preloads the data memory. Bytes arrive over a
// valid/ready handshake, are packed four to a word, and each word is written
// with a one-cycle load_memory strobe at consecutive (wrapping) addresses.
module data_mem_loader
    import data_mem_loader_pkg::*;
#(
    parameter int                LITTLE_ENDIAN = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 8'h00
) (
    input  logic               clk,
    input  logic               data_reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] word_count,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               load_memory,
    output logic [ADDR_W-1:0]  mem_addr_select,
    output logic [31:0]        data_mem_input,
    output logic               busy,
    output logic               done
);

    state_t              state;
    logic [COUNT_W-1:0]  count;
    logic [ADDR_W-1:0]   word_idx;
    logic [ADDR_W-1:0]   last_addr;
    logic [31:0]         last_data;
    logic [ADDR_W-1:0]   write_addr;
    logic [31:0]         asm_word;
    logic [1:0]          asm_idx;
    logic                asm_last;
    logic                transfer;
    logic                last_word;

    assign transfer   = byte_valid & byte_ready;
    assign write_addr = BASE_ADDR + word_idx;
    assign last_word  = (({1'b0, word_idx} + COUNT_W'(1)) == count);

    byte_assembler #(
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_byte_assembler (
        .clk        (clk),
        .data_reset (data_reset),
        .clear      (abort),
        .load_en    (transfer & ~abort),
        .byte_in    (byte_in),
        .word       (asm_word),
        .byte_idx   (asm_idx),
        .last_byte  (asm_last)
    );

    // Session sequencing; abort wins over everything but reset, and the
    // write-port hold registers capture every issued write (even an aborted one)
    always_ff @(posedge clk or posedge data_reset) begin
        if (data_reset) begin
            state     <= IDLE;
            count     <= '0;
            word_idx  <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (state == WRITE) begin
                last_addr <= write_addr;
                last_data <= asm_word;
            end
            if (abort) begin
                state    <= IDLE;
                count    <= '0;
                word_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            count    <= clamp_count(word_count);
                            word_idx <= '0;
                            state    <= (word_count == '0) ? FINISH : COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (transfer && asm_last) begin
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        word_idx <= word_idx + ADDR_W'(1);
                        state    <= last_word ? FINISH : COLLECT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Status and write-port outputs decoded from the current state
    always_comb begin
        byte_ready      = (state == COLLECT);
        load_memory     = (state == WRITE);
        busy            = (state != IDLE);
        done            = (state == FINISH);
        mem_addr_select = load_memory ? write_addr : last_addr;
        data_mem_input  = load_memory ? asm_word   : last_data;
    end

    logic unused_idx;
    assign unused_idx = ^asm_idx;

endmodule
